imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
// - Writer side of the instruction-memory port: receives a program as a byte stream, packs bytes
//   into 32-bit words and writes them into instruction memory via the memory2c-style port.
// - Holds the CPU (PC, register file) in reset until the image is fully loaded, then releases it.
// PARAMETERS
// - BASE_ADDR  32'h0000_0000  byte address of the first word written
// - MAX_WORDS  1024           largest accepted image, in words; must be <= 65535
// PORTS
// - clk             in   1   clock; all state updates on posedge
// - reset           in   1   synchronous, active-high
// - start           in   1   one-cycle pulse; begins a load session
// - in_valid        in   1   byte available on in_data
// - in_data         in   8   stream byte
// - in_ready        out  1   loader accepts in_data this cycle
// - mem_data_in     out  32  write data to instruction memory
// - mem_addr        out  32  byte address to instruction memory
// - mem_enable      out  1   memory enable
// - mem_wr          out  1   memory write strobe
// - mem_createdump  out  1   one-cycle dump request
// - cpu_reset       out  1   reset to the PC and register file
// - busy, done, error out 1  status flags
// - words_written   out  16  number of words committed this session
// BEHAVIOUR
// - Reset: state IDLE; in_ready=0, mem_enable=0, mem_wr=0, mem_createdump=0, mem_addr=BASE_ADDR,
//   mem_data_in=0, cpu_reset=1, busy=0, done=0, error=0, words_written=0. A reset mid-session
//   aborts it immediately; no partial word is written.
// - Byte transfer occurs on a cycle where in_valid && in_ready. in_ready=1 only in LEN_LO, LEN_HI,
//   DATA and CHK.
// - FSM: IDLE -start-> LEN_LO -byte-> LEN_HI -byte-> (len==0 ? DONE : len>MAX_WORDS ? ERROR : DATA).
//   Length is 16 bits, little-endian (first byte is the low byte).
// - DATA: packs 4 bytes little-endian (first byte -> [7:0]); after the 4th byte -> WRITE.
// - WRITE (exactly 1 cycle): mem_enable=1, mem_wr=1, mem_addr=BASE_ADDR+4*words_written,
//   mem_data_in=packed word. words_written increments on the following edge. Then DATA if
//   words_written+1 < len; otherwise CHK if checksum enabled, else DONE.
// - DONE: done=1, busy=0, cpu_reset=0; mem_createdump pulses for exactly the first cycle of DONE.
// - ERROR: error=1, busy=0, cpu_reset=1; held until reset or start.
// - busy=1 in LEN_LO..CHK. start is ignored while busy. start in DONE or ERROR begins a new session:
//   done, error and words_written are cleared and cpu_reset is reasserted.
// - A stalled in_valid never times out; the FSM waits indefinitely.
// - Address wrap: not possible, because MAX_WORDS bounds the address range.
// CONFIGURATION
// - IMEM_LOADER_CHECKSUM_EN defined: after the last word, state CHK accepts one byte. If that byte
//   equals the mod-256 sum of all data bytes (length bytes excluded): DONE, else ERROR. The running
//   sum is cleared on start.
// - Undefined: no CHK state and no trailing byte; the last WRITE goes directly to DONE.
// STRUCTURE
// - imem_loader_pkg: state enum (IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE, ERROR),
//   WORD_BYTES=4, LEN_W=16.
// - Sub-module word_packer: byte-lane shift register plus a 2-bit lane counter; outputs word and
//   word_full; cleared on start and reset.
// TESTING
// - Load of 2 words: bytes 02 00 | 13 00 00 00 | 93 00 10 00 -> writes 0x00000013 @0x0 and
//   0x00100093 @0x4; done=1, cpu_reset=0, words_written=2.
// - Length 0: bytes 00 00 -> DONE with no mem_wr pulse; one mem_createdump pulse.
// - Length MAX_WORDS+1 -> ERROR, cpu_reset=1, no writes; a following start plus valid image -> DONE.
// - in_valid toggled every other cycle during DATA -> same writes, each mem_wr exactly 1 cycle wide,
//   in_ready=0 during WRITE.
// - Reset asserted after 3 data bytes -> all outputs return to reset values; no mem_wr seen.
// - IMEM_LOADER_CHECKSUM_EN: 1-word image 13 00 00 00 + checksum 0x13 -> DONE;
//   checksum 0x14 -> ERROR.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
// Purpose: loader FSM state encoding, word/length geometry and word address helper.
// Ports: none (package).
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int LEN_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERROR
    } state_t;

    // Byte address of word number idx, counted from base.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [LEN_W-1:0] idx);
        return base + {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream input and instruction-memory write port bundle
// Purpose: groups the program byte stream and the memory2c-style write port.
// Ports (signals): in_valid/in_data/in_ready byte stream; mem_data_in, mem_addr, mem_enable,
//   mem_wr, mem_createdump memory port. master = loader side, slave = source/memory side.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic                    in_valid;
    logic [7:0]              in_data;
    logic                    in_ready;
    logic [8*WORD_BYTES-1:0] mem_data_in;
    logic [31:0]             mem_addr;
    logic                    mem_enable;
    logic                    mem_wr;
    logic                    mem_createdump;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_data_in, mem_addr, mem_enable, mem_wr, mem_createdump
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_data_in, mem_addr, mem_enable, mem_wr, mem_createdump
    );

endinterface

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - packs accepted bytes little-endian into 32-bit words
// Purpose: byte-lane shift register plus 2-bit lane counter; first byte lands in [7:0].
// Ports: clk, reset (sync, active-high), clear (session start), byte_valid/byte_data (accepted
//   byte), word (packed word), word_full (the byte accepted this cycle completes the word).
module word_packer
    import imem_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic [8*WORD_BYTES-1:0] word,
    output logic                    word_full
);

    logic [1:0]              lane;
    logic [8*WORD_BYTES-1:0] shreg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane  <= '0;
            shreg <= '0;
        end else if (byte_valid) begin
            lane  <= lane + 2'd1;
            // Shift right so that after four bytes the first one sits in the low lane.
            shreg <= {byte_data, shreg[8*WORD_BYTES-1:8]};
        end
    end

    assign word = shreg;
    // Combinational so the FSM can leave DATA on the same edge that stores the last lane.
    assign word_full = byte_valid && (lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed byte stream into instruction memory
// Purpose: receives a 16-bit little-endian word count followed by program bytes, packs them
//   into words, writes them to consecutive addresses from BASE_ADDR and holds the CPU in reset
//   until the image is complete. Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing
//   mod-256 checksum byte that must match the sum of all data bytes.
// Ports: clk, reset (sync, active-high), start (session pulse), bus (imem_loader_if.master:
//   byte stream + memory port), cpu_reset, busy, done, error, words_written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024           // must be <= 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    imem_loader_if.master    bus,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_written
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

    state_t                  state, state_nxt;
    logic [LEN_W-1:0]        len;
    logic [LEN_W-1:0]        len_full;
    logic                    in_ready_c;
    logic                    fire;
    logic                    start_ok;
    logic                    last_word;
    logic                    word_full;
    logic [8*WORD_BYTES-1:0] word;
    logic                    done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]              sum;
`endif

    assign fire      = bus.in_valid && in_ready_c;
    assign start_ok  = start && (state == IDLE || state == DONE || state == ERROR);
    // Length as it will be once the high byte on the bus is captured.
    assign len_full  = {bus.in_data, len[7:0]};
    assign last_word = ({1'b0, words_written} + 17'd1) >= {1'b0, len};

    word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .byte_valid (fire && state == DATA),
        .byte_data  (bus.in_data),
        .word       (word),
        .word_full  (word_full)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start_ok) state_nxt = LEN_LO;
            end
            LEN_LO: begin
                if (fire) state_nxt = LEN_HI;
            end
            LEN_HI: begin
                if (fire) begin
                    if (len_full == '0)          state_nxt = DONE;
                    else if (len_full > MAX_LEN) state_nxt = ERROR;
                    else                         state_nxt = DATA;
                end
            end
            DATA: begin
                if (fire && word_full) state_nxt = WRITE;
            end
            WRITE: begin
                if (!last_word) state_nxt = DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
                else            state_nxt = CHK;
`else
                else            state_nxt = DONE;
`endif
            end
            CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (fire) state_nxt = (bus.in_data == sum) ? DONE : ERROR;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Session datapath: length, word count, dump edge detect, checksum.
    always_ff @(posedge clk) begin
        if (reset) begin
            len           <= '0;
            words_written <= '0;
            done_q        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum           <= '0;
`endif
        end else begin
            done_q <= (state == DONE);
            if (start_ok) begin
                len           <= '0;
                words_written <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum           <= '0;
`endif
            end
            if (state == LEN_LO && fire) len[7:0]      <= bus.in_data;
            if (state == LEN_HI && fire) len[15:8]     <= bus.in_data;
            if (state == WRITE)          words_written <= words_written + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (state == DATA && fire)   sum           <= sum + bus.in_data;
`endif
        end
    end

    // Output logic
    always_comb begin
        in_ready_c         = 1'b0;
        busy               = 1'b0;
        done               = 1'b0;
        error              = 1'b0;
        cpu_reset          = 1'b1;
        bus.mem_enable     = 1'b0;
        bus.mem_wr         = 1'b0;
        bus.mem_createdump = 1'b0;
        bus.mem_addr       = word_addr(BASE_ADDR, words_written);
        bus.mem_data_in    = '0;
        unique case (state)
            LEN_LO, LEN_HI, DATA, CHK: begin
                in_ready_c = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                busy            = 1'b1;
                bus.mem_enable  = 1'b1;
                bus.mem_wr      = 1'b1;
                bus.mem_data_in = word;
            end
            DONE: begin
                done               = 1'b1;
                cpu_reset          = 1'b0;
                // Dump only on entry; done_q is low on the first DONE cycle.
                bus.mem_createdump = !done_q;
            end
            ERROR: begin
                error = 1'b1;
            end
            default: ;
        endcase
        bus.in_ready = in_ready_c;
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cpu_reset, busy, done, error;
    logic [15:0] words_written;

    imem_loader_if bus();

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .bus           (bus),
        .cpu_reset     (cpu_reset),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] wr_q[$];
    int          dump_cnt, wide_viol, rdy_viol;
    bit          prev_wr;
    logic [7:0]  img[$];
    bit          corrupt_sum = 0;

    // Memory-port monitor: records writes, write-strobe width, ready during write, dump pulses.
    always @(negedge clk) begin
        if (reset) begin
            prev_wr = 1'b0;
        end else begin
            if (bus.mem_wr) begin
                wr_q.push_back({bus.mem_addr, bus.mem_data_in});
                if (prev_wr) wide_viol++;
                if (bus.in_ready || !bus.mem_enable) rdy_viol++;
            end
            if (bus.mem_createdump) dump_cnt++;
            prev_wr = bus.mem_wr;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_mon();
        wr_q.delete();
        dump_cnt  = 0;
        wide_viol = 0;
        rdy_viol  = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 0;
        for (int i = 0; i < gap; i++) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.in_ready) ok = 1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL send_byte: byte %02h not accepted, in_ready=%0b required 1", b, bus.in_ready);
        end
    endtask

    task automatic run_load(input logic [15:0] len, input int glo, input int ghi);
        logic [7:0] sum = 8'd0;
        clear_mon();
        pulse_start();
        send_byte(len[7:0], 0);
        send_byte(len[15:8], $urandom_range(ghi, glo));
        if (len != 0 && len <= MAXW) begin
            foreach (img[i]) begin
                send_byte(img[i], $urandom_range(ghi, glo));
                sum += img[i];
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(corrupt_sum ? sum + 8'd1 : sum, $urandom_range(ghi, glo));
`endif
        end
        for (int n = 0; n < 20 && !(done || error); n++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.mem_enable, bus.mem_wr, bus.mem_createdump, cpu_reset, busy, done, error} !== 8'b0000_1000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b required 00001000",
                {bus.in_ready, bus.mem_enable, bus.mem_wr, bus.mem_createdump, cpu_reset, busy, done, error});
        end
        vectors++;
        if (bus.mem_addr !== BASE || bus.mem_data_in !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mem: addr=%h data=%h required %h/0", bus.mem_addr, bus.mem_data_in, BASE);
        end
        vectors++;
        if (words_written !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_count: words_written=%0d required 0", words_written);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_two_words();
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(16'd2, 0, 0);
        vectors++;
        if (wr_q.size() != 2) begin
            miscompares++;
            $display("FAIL two_words_count: %0d writes required 2", wr_q.size());
        end else begin
            vectors++;
            if (wr_q[0] !== {32'h0, 32'h0000_0013}) begin
                miscompares++;
                $display("FAIL two_words_w0: got %h required 0000000000000013", wr_q[0]);
            end
            vectors++;
            if (wr_q[1] !== {32'h4, 32'h0010_0093}) begin
                miscompares++;
                $display("FAIL two_words_w1: got %h required 0000000400100093", wr_q[1]);
            end
        end
        vectors++;
        if ({done, cpu_reset, busy} !== 3'b100 || words_written !== 16'd2 || dump_cnt != 1) begin
            miscompares++;
            $display("FAIL two_words_status: done=%b cpu_reset=%b busy=%b ww=%0d dumps=%0d required 1 0 0 2 1",
                done, cpu_reset, busy, words_written, dump_cnt);
        end
    endtask

    task automatic test_len_zero();
        img.delete();
        run_load(16'd0, 0, 0);
        vectors++;
        if (wr_q.size() != 0 || done !== 1'b1 || dump_cnt != 1 || words_written !== 16'd0) begin
            miscompares++;
            $display("FAIL len_zero: writes=%0d done=%b dumps=%0d ww=%0d required 0 1 1 0",
                wr_q.size(), done, dump_cnt, words_written);
        end
    endtask

    task automatic test_overflow();
        img.delete();
        run_load(16'(MAXW + 1), 0, 0);
        vectors++;
        if ({error, cpu_reset, busy, done} !== 4'b1100 || wr_q.size() != 0 || dump_cnt != 0) begin
            miscompares++;
            $display("FAIL overflow: error=%b cpu_reset=%b busy=%b done=%b writes=%0d dumps=%0d required 1 1 0 0 0 0",
                error, cpu_reset, busy, done, wr_q.size(), dump_cnt);
        end
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(16'd2, 0, 0);
        vectors++;
        if (done !== 1'b1 || error !== 1'b0 || wr_q.size() != 2) begin
            miscompares++;
            $display("FAIL overflow_recover: done=%b error=%b writes=%0d required 1 0 2", done, error, wr_q.size());
        end
    endtask

    // fixed_gap >= 0 gives a fixed valid pattern; otherwise gaps are random 0..3.
    task automatic test_images(input int count, input int fixed_gap, input string tag);
        for (int t = 0; t < count; t++) begin
            int nw = $urandom_range(6, 1);
            img.delete();
            for (int k = 0; k < 4 * nw; k++) img.push_back(8'($urandom));
            if (fixed_gap >= 0) run_load(16'(nw), fixed_gap, fixed_gap);
            else                run_load(16'(nw), 0, 3);
            vectors++;
            if (wr_q.size() != nw) begin
                miscompares++;
                $display("FAIL %s_count: %0d writes required %0d", tag, wr_q.size(), nw);
            end else begin
                for (int i = 0; i < nw; i++) begin
                    logic [63:0] exp = {BASE + 32'(4 * i), img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
                    vectors++;
                    if (wr_q[i] !== exp) begin
                        miscompares++;
                        $display("FAIL %s_word%0d: got %h required %h", tag, i, wr_q[i], exp);
                    end
                end
            end
            vectors++;
            if (done !== 1'b1 || cpu_reset !== 1'b0 || words_written !== 16'(nw) || dump_cnt != 1
                || wide_viol != 0 || rdy_viol != 0) begin
                miscompares++;
                $display("FAIL %s_status: done=%b cpu_reset=%b ww=%0d dumps=%0d wide=%0d rdy=%0d required 1 0 %0d 1 0 0",
                    tag, done, cpu_reset, words_written, dump_cnt, wide_viol, rdy_viol, nw);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.mem_enable, bus.mem_wr, bus.mem_createdump, cpu_reset, busy, done, error} !== 8'b0000_1000
            || bus.mem_addr !== BASE || bus.mem_data_in !== 32'h0 || words_written !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mid: flags=%b addr=%h data=%h ww=%0d required 00001000 %h 0 0",
                {bus.in_ready, bus.mem_enable, bus.mem_wr, bus.mem_createdump, cpu_reset, busy, done, error},
                bus.mem_addr, bus.mem_data_in, words_written, BASE);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (wr_q.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_nowrite: writes=%0d busy=%b required 0 0", wr_q.size(), busy);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        img = '{8'h13, 8'h00, 8'h00, 8'h00};
        corrupt_sum = 0;
        run_load(16'd1, 0, 0);
        vectors++;
        if (done !== 1'b1 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL checksum_good: done=%b error=%b required 1 0", done, error);
        end
        corrupt_sum = 1;
        run_load(16'd1, 0, 0);
        vectors++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL checksum_bad: error=%b done=%b cpu_reset=%b required 1 0 1", error, done, cpu_reset);
        end
        corrupt_sum = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_two_words();
        test_len_zero();
        test_overflow();
        test_images(2, 1, "toggle");
        test_images(6, -1, "random");
        test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
